// File: rtl/pattern_seq_pkg.sv
// rtl/pattern_seq_pkg.sv - register map, control bits, reset values and FSM states for pattern_sequencer
package pattern_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TEMPO  = 2'd1;
  localparam logic [1:0] REG_LENGTH = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_RESTART   = 1;
  localparam int STATUS_RUNNING = 16;

  localparam int LENGTH_RST = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/tempo_tick_gen.sv
// rtl/tempo_tick_gen.sv - free-running step-tempo counter emitting one tick per period
module tempo_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] count;

  // >= rather than == so a period shrunk below the running count ticks at once
  assign tick = enable && !clear && (count >= period - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - tempo-driven pattern RAM step sequencer; optional PATTERN_SEQ_PREFETCH_EN shadow fetch
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_W      = 12,
  parameter int TEMPO_MIN   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic              AVL_CS,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [1:0]        AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_RDEN,
  input  logic [31:0]       RAM_Q,
  output logic [31:0]       PATTERN,
  output logic [ADDR_W-1:0] STEP,
  output logic              STEP_STROBE
);

  seq_state_e        state;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] step_idx;
  logic              run_q;
  logic [31:0]       tempo_q, tempo_merged, tempo_eff, rd_mux;
  logic [ADDR_W-1:0] length_q, len_merged;
  logic [ADDR_W:0]   idx_inc, len_eff;
  logic [ADDR_W-1:0] step_next;
  logic              idx_over, tick;
  logic              wr, rd, ctrl_wr, start, stop, restart, tempo_wr, len_wr;
`ifdef PATTERN_SEQ_PREFETCH_EN
  logic              pf, shadow_valid;
  logic [31:0]       shadow_q;
  logic [ADDR_W-1:0] shadow_step;
`endif

  assign wr       = AVL_WRITE && AVL_CS;
  assign rd       = AVL_READ && AVL_CS;
  assign ctrl_wr  = wr && (AVL_ADDR == REG_CTRL) && AVL_BYTE_EN[0];
  assign tempo_wr = wr && (AVL_ADDR == REG_TEMPO);
  assign len_wr   = wr && (AVL_ADDR == REG_LENGTH);
  assign start    = ctrl_wr && AVL_WRITEDATA[CTRL_RUN] && !run_q;
  assign stop     = ctrl_wr && !AVL_WRITEDATA[CTRL_RUN] && run_q;
  assign restart  = ctrl_wr && AVL_WRITEDATA[CTRL_RUN] && AVL_WRITEDATA[CTRL_RESTART] && run_q;

  assign tempo_eff = (tempo_q < 32'(TEMPO_MIN)) ? 32'(TEMPO_MIN) : tempo_q;
  // LENGTH of 0 stands for the full 2^ADDR_W address space
  assign len_eff   = (length_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length_q};
  assign idx_inc   = {1'b0, step_idx} + 1'b1;
  assign step_next = (idx_inc >= len_eff) ? '0 : idx_inc[ADDR_W-1:0];
  assign idx_over  = ({1'b0, step_idx} >= len_eff);

  assign RAM_RDEN = (state == ST_FETCH);
  assign RAM_ADDR = step_idx;

  tempo_tick_gen u_tick (
    .clk    (CLK),
    .rst_n  (RESET),
    .clear  (start || restart),
    .enable (run_q),
    .period (tempo_eff),
    .tick   (tick)
  );

  always_comb begin
    tempo_merged = tempo_q;
    len_merged   = length_q;
    for (int b = 0; b < 4; b++)
      if (AVL_BYTE_EN[b]) tempo_merged[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
    for (int i = 0; i < ADDR_W; i++)
      if (AVL_BYTE_EN[i/8]) len_merged[i] = AVL_WRITEDATA[i];
    rd_mux = '0;
    case (AVL_ADDR)
      REG_CTRL:   rd_mux[CTRL_RUN] = run_q;
      REG_TEMPO:  rd_mux = tempo_q;
      REG_LENGTH: rd_mux[ADDR_W-1:0] = length_q;
      default: begin
        rd_mux[ADDR_W-1:0]     = STEP;
        rd_mux[STATUS_RUNNING] = run_q;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      run_q        <= 1'b0;
      tempo_q      <= 32'(TEMPO_MIN);
      length_q     <= ADDR_W'(LENGTH_RST);
      AVL_READDATA <= '0;
    end else begin
      if (start) run_q <= 1'b1;
      else if (stop) run_q <= 1'b0;
      if (tempo_wr) tempo_q <= tempo_merged;
      if (len_wr) length_q <= len_merged;
      AVL_READDATA <= rd ? rd_mux : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      step_idx    <= '0;
      PATTERN     <= '0;
      STEP        <= '0;
      STEP_STROBE <= 1'b0;
`ifdef PATTERN_SEQ_PREFETCH_EN
      pf           <= 1'b0;
      shadow_valid <= 1'b0;
      shadow_q     <= '0;
      shadow_step  <= '0;
`endif
    end else begin
      STEP_STROBE <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
      end else if (start || restart) begin
        step_idx <= '0;
        state    <= ST_FETCH;
`ifdef PATTERN_SEQ_PREFETCH_EN
        pf           <= 1'b0;
        shadow_valid <= 1'b0;
`endif
      end else begin
        case (state)
          ST_FETCH: begin
            wait_cnt <= '0;
            state    <= (RAM_LATENCY == 1) ? ST_LATCH : ST_WAIT;
          end
          ST_WAIT: begin
            if (wait_cnt == 2'(RAM_LATENCY - 2)) state <= ST_LATCH;
            else wait_cnt <= wait_cnt + 2'd1;
          end
          ST_LATCH: begin
            step_idx <= step_next;
`ifdef PATTERN_SEQ_PREFETCH_EN
            if (pf) begin
              shadow_q     <= RAM_Q;
              shadow_step  <= step_idx;
              shadow_valid <= 1'b1;
              state        <= ST_HOLD;
            end else begin
              PATTERN     <= RAM_Q;
              STEP        <= step_idx;
              STEP_STROBE <= 1'b1;
              pf          <= 1'b1;
              state       <= ST_FETCH;
            end
`else
            PATTERN     <= RAM_Q;
            STEP        <= step_idx;
            STEP_STROBE <= 1'b1;
            state       <= ST_HOLD;
`endif
          end
          ST_HOLD: begin
            if (tick) begin
              state <= ST_FETCH;
`ifdef PATTERN_SEQ_PREFETCH_EN
              if (shadow_valid && !len_wr) begin
                PATTERN      <= shadow_q;
                STEP         <= shadow_step;
                STEP_STROBE  <= 1'b1;
                shadow_valid <= 1'b0;
                pf           <= 1'b1;
              end else begin
                pf <= 1'b0;
                if (idx_over) step_idx <= '0;
              end
`else
              if (idx_over) step_idx <= '0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
`ifdef PATTERN_SEQ_PREFETCH_EN
        // a new LENGTH may put the prefetched step out of range: drop it and refetch on the tick
        if (len_wr) begin
          shadow_valid <= 1'b0;
          if ((pf || state == ST_LATCH) &&
              (state == ST_FETCH || state == ST_WAIT || state == ST_LATCH))
            state <= ST_HOLD;
        end
`endif
      end
    end
  end

endmodule
